serial_subtractor: RTL and testbench

Bit-serial, LSB-first subtractor computing D = A - B over WIDTH clock cycles. It is the inverse-direction companion to the team's adder blocks. Each cycle one bit passes through a full-subtractor cell built from two half subtractors, with the borrow held in a flip-flop between bits. A start/busy/done handshake lets a controller or bench launch one operation at a time.

---
 rtl/serial_subtractor_pkg.sv | 15 +
 rtl/half_subtractor.sv | 12 +
 rtl/serial_subtractor.sv | 126 ++++++++++++
 tb/tb_serial_subtractor.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and counter sizing.
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Bit-counter width; never below one bit so the counter is always a real vector.
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/half_subtractor.sv
// Half subtractor: d = x - y for single bits, bo = borrow out.
module half_subtractor (
   input  logic x,
   input  logic y,
   output logic d,
   output logic bo
);

   assign d  = x ^ y;
   assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor D = A - B over WIDTH cycles with start/busy/done handshake.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             Bout,
   output logic             ovf
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state, state_next;
   logic [WIDTH-1:0] sa, sb, sr;
   logic [CW-1:0]    cnt;
   logic             borrow;
   logic             d1, b1, d_bit, b2, bit_borrow;
   logic             last;
   logic [WIDTH-1:0] next_sr;

   // Full-subtractor cell built from two half subtractors.
   half_subtractor u_hs_ab (
      .x  (sa[0]),
      .y  (sb[0]),
      .d  (d1),
      .bo (b1)
   );

   half_subtractor u_hs_borrow (
      .x  (d1),
      .y  (borrow),
      .d  (d_bit),
      .bo (b2)
   );

   assign bit_borrow = b1 | b2;
   assign next_sr    = {d_bit, sr[WIDTH-1:1]};
   assign last       = (cnt == CW'(WIDTH - 1));
   assign busy       = (state != S_IDLE);
   assign done       = (state == S_DONE);

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start) state_next = S_RUN;
         S_RUN:   if (last)  state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // NOTE: the working registers are reset too, so an aborted op leaves no stale bits behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa     <= '0;
         sb     <= '0;
         sr     <= '0;
         cnt    <= '0;
         borrow <= 1'b0;
         D      <= '0;
         Bout   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  sa     <= a;
                  sb     <= b;
                  cnt    <= '0;
                  borrow <= 1'b0;
               end
            end
            S_RUN: begin
               sa     <= sa >> 1;
               sb     <= sb >> 1;
               sr     <= next_sr;
               borrow <= bit_borrow;
               cnt    <= cnt + 1'b1;
               if (last) begin
                  D    <= next_sr;
                  Bout <= bit_borrow;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   logic a_sign, b_sign, ovf_q;

   // Operand sign bits are kept separately because sa/sb are shifted away during RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sign <= 1'b0;
         b_sign <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (state == S_IDLE && start) begin
         a_sign <= a[WIDTH-1];
         b_sign <= b[WIDTH-1];
      end else if (state == S_RUN && last) begin
         ovf_q <= (a_sign != b_sign) && (next_sr[WIDTH-1] != a_sign);
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus random ops against an arithmetic model.
module tb_serial_subtractor;

   localparam int WIDTH   = 8;
   localparam int TIMEOUT = 60;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a, b;
   logic             busy, done, Bout, ovf;
   logic [WIDTH-1:0] D;

   int n_checks = 0;
   int n_fail   = 0;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .D     (D),
      .Bout  (Bout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on the operands.
   function automatic logic [WIDTH-1:0] exp_d(input int unsigned x, input int unsigned y);
      int r;
      r = int'(x) - int'(y);
      return WIDTH'((r + (1 << WIDTH)) % (1 << WIDTH));
   endfunction

   function automatic logic exp_bout(input int unsigned x, input int unsigned y);
      return x < y;
   endfunction

   function automatic logic exp_ovf(input int unsigned x, input int unsigned y);
`ifdef SERIAL_SUB_OVF_EN
      int sx, sy, r;
      sx = (x >= (1 << (WIDTH - 1))) ? int'(x) - (1 << WIDTH) : int'(x);
      sy = (y >= (1 << (WIDTH - 1))) ? int'(y) - (1 << WIDTH) : int'(y);
      r  = sx - sy;
      return (r > (1 << (WIDTH - 1)) - 1) || (r < -(1 << (WIDTH - 1)));
`else
      return (x > y) && (x < y);
`endif
   endfunction

   // Wait (sampling on falling edges) until done is seen; returns edges waited.
   task automatic wait_done(output int edges);
      edges = 0;
      while (!done && edges < TIMEOUT) begin
         @(negedge clk);
         edges++;
      end
   endtask

   // Launch one op, scramble inputs after capture, and check results and latency.
   task automatic run_op(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      int edges;
      @(negedge clk);
      a = x; b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      wait_done(edges);
      check({tag, " latency"}, edges + 1, WIDTH + 1);
      check({tag, " D"}, D, exp_d(x, y));
      check({tag, " Bout"}, Bout, exp_bout(x, y));
      check({tag, " ovf"}, ovf, exp_ovf(x, y));
      check({tag, " busy in DONE"}, busy, 1'b1);
      @(negedge clk);
      check({tag, " done pulse width"}, done, 1'b0);
      check({tag, " idle after done"}, busy, 1'b0);
   endtask

   initial begin
      int edges, extra_dones;
      logic [WIDTH-1:0] x, y;

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      #12;
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      check("reset D", D, '0);
      check("reset Bout", Bout, 1'b0);
      check("reset ovf", ovf, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("35-12", 8'h35, 8'h12);
      run_op("12-35", 8'h12, 8'h35);
      run_op("00-01", 8'h00, 8'h01);
      run_op("FF-FF", 8'hFF, 8'hFF);
      run_op("80-01", 8'h80, 8'h01);
      run_op("7F-FF", 8'h7F, 8'hFF);

      // Start re-pulsed during RUN must be ignored.
      @(negedge clk);
      a = 8'h35; b = 8'h12; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      a = 8'hAA; b = 8'h55; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy D held mid-run", D, exp_d(8'h7F, 8'hFF));
      wait_done(edges);
      check("busy op done seen", done, 1'b1);
      check("busy op D", D, 8'h23);
      extra_dones = 0;
      for (int i = 0; i < WIDTH + 4; i++) begin
         @(negedge clk);
         if (done) extra_dones++;
      end
      check("busy op single done", extra_dones, 0);
      check("busy op D stable", D, 8'h23);
      run_op("AA-55", 8'hAA, 8'h55);

      // Reset in the middle of RUN aborts immediately.
      @(negedge clk);
      a = 8'h10; b = 8'h01; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort busy", busy, 1'b0);
      check("abort done", done, 1'b0);
      check("abort D", D, '0);
      check("abort Bout", Bout, 1'b0);
      check("abort ovf", ovf, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      extra_dones = 0;
      for (int i = 0; i < WIDTH + 4; i++) begin
         @(negedge clk);
         if (done || busy) extra_dones++;
      end
      check("abort no activity", extra_dones, 0);
      run_op("10-01", 8'h10, 8'h01);

      // Start held high: second op launches on the first IDLE edge.
      @(negedge clk);
      a = 8'h64; b = 8'h9C; start = 1'b1;
      @(negedge clk);
      wait_done(edges);
      check("held first D", D, exp_d(8'h64, 8'h9C));
      check("held first ovf", ovf, exp_ovf(8'h64, 8'h9C));
      a = 8'h03; b = 8'h07;
      edges = 0;
      do begin
         @(negedge clk);
         edges++;
      end while (!done && edges < TIMEOUT);
      check("held throughput", edges, WIDTH + 2);
      check("held second D", D, exp_d(8'h03, 8'h07));
      check("held second Bout", Bout, exp_bout(8'h03, 8'h07));
      start = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 30; i++) begin
         x = WIDTH'($urandom);
         y = WIDTH'($urandom);
         run_op("random", x, y);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
